// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO register pair fed by the EX-stage ALU.
// It can also run an iterative radix-2 restoring divider (div/divu).
// Optional feature macro: HILO_DIV_EN.
//   Defined   -> divider FSM compiled in. Busy stalls the pipeline while a
//                division is in flight.
//   Undefined -> plain HI/LO register pair. Busy, DivDone and DivByZero
//                are tied low.
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             WriteHI,
    input  logic             WriteLO,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] ALUResultHI,
    input  logic             DivStart,
    input  logic             DivSigned,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             DivDone,
    output logic             DivByZero
);

    logic [WIDTH-1:0] hi_q, lo_q;

    assign HI = hi_q;
    assign LO = lo_q;

`ifdef HILO_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, araw_q;
    logic             sgn_a_q, sgn_b_q, bz_q;
    logic             busy_q, done_q, dbz_q;

    logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] quo_sh;
    logic             unused_rem_top;

    // The remainder never exceeds the divisor, so its top bit is only a
    // sign bit for the trial subtraction. It is never carried into the
    // next step.
    assign unused_rem_top = rem_q[WIDTH];

    assign Busy      = busy_q;
    assign DivDone   = done_q;
    assign DivByZero = dbz_q;

    // Operand magnitudes, one restoring step, and sign fix-up of the result
    always_comb begin
        a_mag  = (DivSigned && A[WIDTH-1]) ? -A : A;
        b_mag  = (DivSigned && B[WIDTH-1]) ? -B : B;
        rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        quo_sh = {quo_q[WIDTH-2:0], 1'b0};
        diff   = rem_sh - {1'b0, dvs_q};
        rem_d  = rem_sh;
        quo_d  = quo_sh;
        if (!diff[WIDTH]) begin
            rem_d = diff;
            quo_d = quo_sh | WIDTH'(1);
        end
        // sgn_*_q are already gated with DivSigned at start
        quo_fix = (sgn_a_q ^ sgn_b_q) ? -quo_q : quo_q;
        rem_fix = sgn_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    // Divider FSM. It also owns HI/LO, since writes are only honoured in IDLE.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            araw_q  <= '0;
            sgn_a_q <= 1'b0;
            sgn_b_q <= 1'b0;
            bz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (WriteHI) hi_q <= ALUResultHI;
                    if (WriteLO) lo_q <= ALUResult;
                    if (DivStart) begin
                        sgn_a_q <= DivSigned & A[WIDTH-1];
                        sgn_b_q <= DivSigned & B[WIDTH-1];
                        quo_q   <= a_mag;
                        dvs_q   <= b_mag;
                        araw_q  <= A;
                        bz_q    <= (B == '0);
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    if (bz_q) begin
                        lo_q <= '1;
                        hi_q <= araw_q;
                    end else begin
                        lo_q <= quo_fix;
                        hi_q <= rem_fix;
                    end
                    done_q  <= 1'b1;
                    dbz_q   <= bz_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
`else
    logic unused_div;

    assign unused_div = ^{DivStart, DivSigned, A, B};
    assign Busy       = 1'b0;
    assign DivDone    = 1'b0;
    assign DivByZero  = 1'b0;

    // Plain HI/LO capture of ALU results
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (WriteHI) hi_q <= ALUResultHI;
            if (WriteLO) lo_q <= ALUResult;
        end
    end
`endif

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Architectural HI/LO register pair with an iterative 32-bit divider, sitting directly downstream of the 32-bit ALU in the EX stage. It captures the ALU's 64-bit multiply, madd and msub results and its mthi/mtlo results into HI/LO. HI/LO feed back into the ALU's HI/LO operand inputs. It also executes div/divu as a multi-cycle operation and asserts a stall request while busy.

## Interface
- `WIDTH`, 32, datapath width; the divider iteration count equals WIDTH.

- `Clk`  in  1  single clock, rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `WriteHI`  in  1  load HI from `ALUResultHI` (mult, multu, madd, msub, mthi).
- `WriteLO`  in  1  load LO from `ALUResult` (mult, multu, madd, msub, mtlo).
- `ALUResult`  in  WIDTH  ALU low result.
- `ALUResultHI`  in  WIDTH  ALU high result.
- `DivStart`  in  1  start a division; sampled only in IDLE.
- `DivSigned`  in  1  1 = div (signed), 0 = divu; sampled with `DivStart`.
- `A`  in  WIDTH  dividend (rs).
- `B`  in  WIDTH  divisor (rt).
- `HI`  out  WIDTH  HI register; reset 0.
- `LO`  out  WIDTH  LO register; reset 0.
- `Busy`  out  1  stall request while a division is in flight; reset 0.
- `DivDone`  out  1  one-cycle pulse when a division result lands in HI/LO; reset 0.
- `DivByZero`  out  1  pulses together with `DivDone` when B was 0; reset 0.

## Operation
- **States:** IDLE, DIV, FIX. Reset forces IDLE, HI=LO=0, all flags 0, and the iteration counter to 0.
- **IDLE:**
  - `WriteHI`/`WriteLO` update HI/LO at the clock edge, independently of each other.
  - If `DivStart` is high, the block latches the sign flags, |A| and |B| (magnitudes only when `DivSigned`; raw operands otherwise), the raw A, and the B==0 flag. It clears the partial remainder, sets the counter to 0 and goes to DIV.
  - Writes and `DivStart` in the same cycle are both honoured: the write lands now, and the division result later overwrites both registers.
- **DIV:**
  - Performs one radix-2 restoring step per cycle: shift the {remainder, quotient} pair left by 1; trial-subtract the divisor; keep the difference and set quotient bit 0 if it is non-negative.
  - The remainder register is WIDTH+1 bits wide.
  - After WIDTH steps, goes to FIX.
- **FIX:**
  - Normal case: the quotient is negated if `DivSigned` and the signs of A and B differ. The remainder takes the sign of A when `DivSigned`. LO ← quotient, HI ← remainder.
  - Divide by zero: LO ← all ones, HI ← raw A, regardless of signedness.
  - Goes to IDLE.
- **Signed overflow:** 0x80000000 / −1 wraps, giving LO=0x80000000 and HI=0.
- **While Busy:** `WriteHI`, `WriteLO` and `DivStart` are ignored. The pipeline is stalled by `Busy`, so this does not occur in correct operation.
- **Reset mid-division:** aborts the division. No result is written; HI/LO return to 0.

## Timing
- HI/LO writes: value visible on `HI`/`LO` the cycle after `WriteHI`/`WriteLO` (one register stage).
- Division, with edge E0 being the one that samples `DivStart`:
  - E1..E32: iterations.
  - E33: FIX writes HI/LO.
  - `Busy` is high from after E0 until after E33, i.e. 33 cycles.
  - `DivDone` (and `DivByZero` if applicable) is high for exactly the cycle following E33. HI/LO are valid in that same cycle.
- Back-to-back: a new `DivStart` is accepted in the cycle `DivDone` is high (IDLE).
- `Busy` is a registered output with no combinational path from inputs.

## Configuration
- Macro: `HILO_DIV_EN`.
- **Defined:** the divider, the FSM and all division behaviour described above are compiled in.
- **Undefined:**
  - Divider logic is removed and `DivStart`/`DivSigned` are ignored.
  - `Busy`, `DivDone` and `DivByZero` are tied to 0.
  - The block is the HI/LO register pair only; write behaviour and reset values are unchanged.

## Test plan
- **Reset:** assert `Rst` for 2 cycles with random inputs → HI=0, LO=0, `Busy`=0, `DivDone`=0.
- **Register writes:**
  - `WriteHI`=`WriteLO`=1, `ALUResultHI`=0x12345678, `ALUResult`=0x9ABCDEF0 → next cycle HI=0x12345678, LO=0x9ABCDEF0.
  - `WriteLO` alone with 0x1 → HI unchanged.
- **Unsigned divide:** divu A=100, B=7 → `Busy` high 33 cycles; `DivDone` pulse; LO=14, HI=2.
- **Signed divide:** div A=−7 (0xFFFFFFF9), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Edge cases:**
  - div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu A=5, B=0 → LO=0xFFFFFFFF, HI=5, `DivByZero`=1 with `DivDone`.
- **Abort and blocking:**
  - Start divu 100/7, assert `Rst` 10 cycles later → next cycle `Busy`=0, HI=LO=0, and no `DivDone` follows.
  - `WriteHI` pulsed while `Busy` → HI unchanged.
